id_ex_pipe: RTL and testbench

Parametrised, elastic ID/EX pipeline register for the Beyonce core. It carries a packed payload (instruction, PC, operands, register indices) and a separate control field (reg_write, mem_read, mem_write, mem_to_reg, alu_src, alu_op, …) from decode to execute. It supports 1–4 register stages, valid/ready backpressure, and a synchronous flush that inserts bubbles with all control bits zeroed. It sits between the decode and execute stages, replacing the fixed single-stage register.

---
 rtl/id_ex_pipe.sv | 113 +++++++++++
 tb/tb_id_ex_pipe.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe.sv
// Elastic ID/EX pipeline register: DEPTH valid/ready stages carrying payload + control.
// Ports: clk, reset(active-low sync), in_*/out_* handshakes, flush, occupancy, stall_cycles.
module id_ex_pipe #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16,
  localparam int OCC_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [OCC_W-1:0]  occupancy,
  output logic [CNT_W-1:0]  stall_cycles
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("id_ex_pipe: DEPTH must be in 1..4");
  end

  logic [DEPTH-1:0]  vld;
  logic [DATA_W-1:0] dat [DEPTH];
  logic [CTRL_W-1:0] ctl [DEPTH];

  logic [DEPTH-1:0]  rdy;
  logic              acc;
  logic [DEPTH-1:0]  up_v;
  logic [DATA_W-1:0] up_d [DEPTH];
  logic [CTRL_W-1:0] up_c [DEPTH];

  logic in_xfer;
  logic out_xfer;
  logic stall_now;

  // A stage is ready if it or any stage after it is empty, or
  // the consumer takes the output beat.
  always_comb begin
    acc = out_ready;
    rdy = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      acc    = acc | !vld[i];
      rdy[i] = acc;
    end
  end

  always_comb begin
    up_v[0] = in_valid;
    up_d[0] = in_data;
    up_c[0] = in_ctrl;
    for (int i = 1; i < DEPTH; i++) begin
      up_v[i] = vld[i-1];
      up_d[i] = dat[i-1];
      up_c[i] = ctl[i-1];
    end
  end

  assign in_ready  = reset & rdy[0];
  assign out_valid = vld[DEPTH-1];
  assign out_data  = dat[DEPTH-1];
  assign out_ctrl  = ctl[DEPTH-1];

  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_valid & out_ready;
  assign stall_now = out_valid & !out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      vld          <= '0;
      occupancy    <= '0;
      stall_cycles <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat[i] <= '0;
        ctl[i] <= '0;
      end
    end else begin
      if (stall_now && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (flush) begin
        // Squash: kill valids and control, leave data as-is.
        vld       <= '0;
        occupancy <= '0;
        for (int i = 0; i < DEPTH; i++)
          ctl[i] <= '0;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (rdy[i]) begin
            vld[i] <= up_v[i];
            if (up_v[i]) begin
              dat[i] <= up_d[i];
              ctl[i] <= up_c[i];
            end else begin
              ctl[i] <= '0;
            end
          end
        end
        case ({in_xfer, out_xfer})
          2'b10:   occupancy <= occupancy + OCC_W'(1);
          2'b01:   occupancy <= occupancy - OCC_W'(1);
          default: occupancy <= occupancy;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe at DEPTH 2, 3 and 4 (CNT_W=4).
// Scoreboard queue tracks accepted beats; tasks check per-cycle tables.
module tb_id_ex_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic        flush;
  logic        out_ready;

  logic        ir [3];
  logic        ov [3];
  logic [31:0] od [3];
  logic [7:0]  oc [3];
  logic [1:0]  occ2, occ3;
  logic [2:0]  occ4;
  logic [15:0] st2, st3;
  logic [3:0]  st4;

  int sel;
  int vec;
  int bad;

  logic        o_ir, o_ov;
  logic [31:0] o_od;
  logic [7:0]  o_oc;
  logic [2:0]  o_occ;
  logic [15:0] o_st;

  logic [39:0] q [$];
  logic [39:0] sb_exp;

  id_ex_pipe #(.DEPTH(2)) u_d2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]),
    .out_ctrl(oc[0]), .occupancy(occ2), .stall_cycles(st2)
  );

  id_ex_pipe #(.DEPTH(3)) u_d3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]),
    .out_ctrl(oc[1]), .occupancy(occ3), .stall_cycles(st3)
  );

  id_ex_pipe #(.DEPTH(4), .CNT_W(4)) u_d4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]),
    .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
    .out_valid(ov[2]), .out_ready(out_ready), .out_data(od[2]),
    .out_ctrl(oc[2]), .occupancy(occ4), .stall_cycles(st4)
  );

  always_comb begin
    o_ir  = ir[0];
    o_ov  = ov[0];
    o_od  = od[0];
    o_oc  = oc[0];
    o_occ = {1'b0, occ2};
    o_st  = st2;
    case (sel)
      1: begin
        o_ir = ir[1]; o_ov = ov[1]; o_od = od[1]; o_oc = oc[1];
        o_occ = {1'b0, occ3}; o_st = st3;
      end
      2: begin
        o_ir = ir[2]; o_ov = ov[2]; o_od = od[2]; o_oc = oc[2];
        o_occ = occ4; o_st = {12'd0, st4};
      end
      default: ;
    endcase
  end

  // Scoreboard: pop on output transfer, push accepted input beats.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (o_ov && out_ready) begin
        vec++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra: got %h/%h, want no beat", o_od, o_oc);
        end else begin
          sb_exp = q.pop_front();
          if ({o_oc, o_od} !== sb_exp) begin
            bad++;
            $display("FAIL sb_beat: got %h/%h, want %h/%h",
                     o_od, o_oc, sb_exp[31:0], sb_exp[39:32]);
          end
        end
      end
      if (!o_ov) begin
        vec++;
        if (o_oc !== 8'h00) begin
          bad++;
          $display("FAIL bubble_ctrl: got %h, want 00", o_oc);
        end
      end
      if (flush)
        q.delete();
      else if (in_valid && o_ir)
        q.push_back({in_ctrl, in_data});
    end else begin
      q.delete();
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int s);
    sel = s;
    reset = 1'b0;
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    in_data = '0;
    in_ctrl = '0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    sel = 0;
    reset = 1'b0;
    in_valid = 1'b1;
    in_data = 32'hFFFF_FFFF;
    in_ctrl = 8'hFF;
    out_ready = 1'b1;
    flush = 1'b0;
    @(negedge clk);
    vec++;
    if (o_ir !== 1'b0) begin
      bad++; $display("FAIL rst_ready0: got %b, want 0", o_ir);
    end
    tick();
    @(negedge clk);
    vec++;
    if (o_ov !== 1'b0) begin
      bad++; $display("FAIL rst_valid: got %b, want 0", o_ov);
    end
    vec++;
    if (o_od !== 32'h0) begin
      bad++; $display("FAIL rst_data: got %h, want 0", o_od);
    end
    vec++;
    if (o_oc !== 8'h0) begin
      bad++; $display("FAIL rst_ctrl: got %h, want 0", o_oc);
    end
    vec++;
    if (o_occ !== 3'd0) begin
      bad++; $display("FAIL rst_occ: got %0d, want 0", o_occ);
    end
    vec++;
    if (o_st !== 16'd0) begin
      bad++; $display("FAIL rst_stall: got %0d, want 0", o_st);
    end
    vec++;
    if (o_ir !== 1'b0) begin
      bad++; $display("FAIL rst_ready: got %b, want 0", o_ir);
    end
    tick();
    reset = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic test_stream();
    bit          iv_t [5] = '{1, 1, 0, 0, 0};
    bit          ov_t [5] = '{0, 0, 1, 1, 0};
    int          oc_t [5] = '{0, 1, 2, 1, 0};
    logic [31:0] d_t  [5] = '{32'h1234_5678, 32'h8765_4321, 0, 0, 0};
    logic [7:0]  c_t  [5] = '{8'h2B, 8'h0D, 0, 0, 0};
    do_reset(0);
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = iv_t[c];
      in_data = d_t[c];
      in_ctrl = c_t[c];
      @(negedge clk);
      vec++;
      if (o_ov !== ov_t[c]) begin
        bad++; $display("FAIL st_valid c=%0d: got %b, want %b", c, o_ov, ov_t[c]);
      end
      vec++;
      if (o_occ !== 3'(oc_t[c])) begin
        bad++; $display("FAIL st_occ c=%0d: got %0d, want %0d", c, o_occ, oc_t[c]);
      end
      vec++;
      if (o_ir !== 1'b1) begin
        bad++; $display("FAIL st_ready c=%0d: got %b, want 1", c, o_ir);
      end
      if (ov_t[c]) begin
        vec++;
        if ({o_oc, o_od} !== {c_t[c-2], d_t[c-2]}) begin
          bad++;
          $display("FAIL st_beat c=%0d: got %h/%h, want %h/%h",
                   c, o_od, o_oc, d_t[c-2], c_t[c-2]);
        end
      end
      tick();
    end
    vec++;
    if (q.size() != 0) begin
      bad++; $display("FAIL st_drain: got %0d left, want 0", q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a = 32'h1234_5678;
    logic [31:0] b = 32'h8765_4321;
    logic [31:0] k = 32'h3333_3333;
    bit          or_t [10] = '{1, 0, 0, 0, 0, 0, 1, 1, 1, 1};
    bit          iv_t [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    bit          ir_t [10] = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
    bit          ov_t [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    int          oc_t [10] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 0};
    int          st_t [10] = '{0, 0, 0, 1, 2, 3, 4, 4, 4, 4};
    logic [31:0] od_t [10] = '{0, 0, a, a, a, a, a, b, k, 0};
    do_reset(0);
    for (int c = 0; c < 10; c++) begin
      out_ready = or_t[c];
      in_valid = iv_t[c];
      in_data = (c == 0) ? a : (c == 1) ? b : k;
      in_ctrl = (c == 0) ? 8'h2B : (c == 1) ? 8'h0D : 8'h55;
      @(negedge clk);
      vec++;
      if (o_ir !== ir_t[c]) begin
        bad++; $display("FAIL bp_ready c=%0d: got %b, want %b", c, o_ir, ir_t[c]);
      end
      vec++;
      if (o_ov !== ov_t[c]) begin
        bad++; $display("FAIL bp_valid c=%0d: got %b, want %b", c, o_ov, ov_t[c]);
      end
      vec++;
      if (o_occ !== 3'(oc_t[c])) begin
        bad++; $display("FAIL bp_occ c=%0d: got %0d, want %0d", c, o_occ, oc_t[c]);
      end
      vec++;
      if (o_st !== 16'(st_t[c])) begin
        bad++; $display("FAIL bp_stall c=%0d: got %0d, want %0d", c, o_st, st_t[c]);
      end
      if (ov_t[c]) begin
        vec++;
        if (o_od !== od_t[c]) begin
          bad++; $display("FAIL bp_data c=%0d: got %h, want %h", c, o_od, od_t[c]);
        end
      end
      tick();
    end
    vec++;
    if (q.size() != 0) begin
      bad++; $display("FAIL bp_drain: got %0d left, want 0", q.size());
    end
  endtask

  task automatic test_flush();
    bit          iv_t [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
    bit          fl_t [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
    bit          or_t [9] = '{0, 0, 0, 1, 1, 1, 1, 1, 1};
    bit          ov_t [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    int          oc_t [9] = '{0, 1, 2, 3, 0, 1, 1, 1, 0};
    logic [31:0] d_t  [9] = '{32'h0000_00A1, 32'h0000_00A2, 32'h0000_00A3,
                              32'hAABB_CCDD, 32'h0000_000C, 0, 0, 0, 0};
    do_reset(1);
    for (int c = 0; c < 9; c++) begin
      in_valid = iv_t[c];
      flush = fl_t[c];
      out_ready = or_t[c];
      in_data = d_t[c];
      in_ctrl = 8'(c + 8'h40);
      @(negedge clk);
      vec++;
      if (o_ir !== 1'b1) begin
        bad++; $display("FAIL fl_ready c=%0d: got %b, want 1", c, o_ir);
      end
      vec++;
      if (o_ov !== ov_t[c]) begin
        bad++; $display("FAIL fl_valid c=%0d: got %b, want %b", c, o_ov, ov_t[c]);
      end
      vec++;
      if (o_occ !== 3'(oc_t[c])) begin
        bad++; $display("FAIL fl_occ c=%0d: got %0d, want %0d", c, o_occ, oc_t[c]);
      end
      vec++;
      if (o_ov === 1'b1 && o_od === 32'hAABB_CCDD) begin
        bad++; $display("FAIL fl_killed c=%0d: got %h, want it dropped", c, o_od);
      end
      if (c == 3 || c == 7) begin
        vec++;
        if (o_od !== ((c == 3) ? 32'h0000_00A1 : 32'h0000_000C)) begin
          bad++; $display("FAIL fl_data c=%0d: got %h", c, o_od);
        end
      end
      if (c == 4) begin
        vec++;
        if (o_oc !== 8'h00) begin
          bad++; $display("FAIL fl_ctrl: got %h, want 00", o_oc);
        end
      end
      tick();
    end
    flush = 1'b0;
    vec++;
    if (q.size() != 0) begin
      bad++; $display("FAIL fl_drain: got %0d left, want 0", q.size());
    end
  endtask

  task automatic test_simul();
    int oc_t [13] = '{0, 1, 2, 3, 4, 4, 4, 4, 4, 3, 2, 1, 0};
    do_reset(2);
    for (int c = 0; c < 13; c++) begin
      out_ready = (c >= 4);
      in_valid = (c < 8);
      in_data = 32'hB000_0000 + 32'(c + 1);
      in_ctrl = 8'(c + 1);
      @(negedge clk);
      vec++;
      if (o_occ !== 3'(oc_t[c])) begin
        bad++; $display("FAIL sim_occ c=%0d: got %0d, want %0d", c, o_occ, oc_t[c]);
      end
      vec++;
      if (o_ov !== (c >= 4 && c < 12)) begin
        bad++; $display("FAIL sim_valid c=%0d: got %b", c, o_ov);
      end
      if (c < 8) begin
        vec++;
        if (o_ir !== 1'b1) begin
          bad++; $display("FAIL sim_ready c=%0d: got %b, want 1", c, o_ir);
        end
      end
      if (c >= 4 && c < 12) begin
        vec++;
        if (o_od !== 32'hB000_0000 + 32'(c - 3)) begin
          bad++; $display("FAIL sim_data c=%0d: got %h, want %h",
                          c, o_od, 32'hB000_0000 + 32'(c - 3));
        end
      end
      tick();
    end
    vec++;
    if (q.size() != 0) begin
      bad++; $display("FAIL sim_drain: got %0d left, want 0", q.size());
    end
  endtask

  task automatic test_saturate_reset();
    int exp_st;
    do_reset(2);
    out_ready = 1'b0;
    for (int c = 0; c < 24; c++) begin
      in_valid = 1'b1;
      in_data = 32'hC000_0000 + 32'(c);
      in_ctrl = 8'(c + 8'h80);
      @(negedge clk);
      exp_st = (c > 4) ? c - 4 : 0;
      if (exp_st > 15) exp_st = 15;
      vec++;
      if (o_st !== 16'(exp_st)) begin
        bad++; $display("FAIL sat_stall c=%0d: got %0d, want %0d", c, o_st, exp_st);
      end
      tick();
    end
    reset = 1'b0;
    @(negedge clk);
    vec++;
    if (o_st !== 16'd15) begin
      bad++; $display("FAIL sat_final: got %0d, want 15", o_st);
    end
    vec++;
    if (o_occ !== 3'd4 || o_ov !== 1'b1) begin
      bad++; $display("FAIL sat_full: got occ=%0d v=%b, want 4/1", o_occ, o_ov);
    end
    vec++;
    if (o_ir !== 1'b0) begin
      bad++; $display("FAIL mid_rst_ready: got %b, want 0", o_ir);
    end
    tick();
    reset = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    vec++;
    if ({o_ov, o_od, o_oc} !== 41'd0) begin
      bad++; $display("FAIL mid_rst_out: got v=%b d=%h c=%h, want 0", o_ov, o_od, o_oc);
    end
    vec++;
    if (o_occ !== 3'd0 || o_st !== 16'd0) begin
      bad++; $display("FAIL mid_rst_cnt: got occ=%0d st=%0d, want 0/0", o_occ, o_st);
    end
    vec++;
    if (o_ir !== 1'b1) begin
      bad++; $display("FAIL mid_rst_ready: got %b, want 1", o_ir);
    end
    tick();
  endtask

  initial begin
    vec = 0;
    bad = 0;
    sel = 0;
    reset = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_ctrl = '0;
    flush = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_simul();
    test_saturate_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
